// File: rtl/seq_mult_fsm.sv
// rtl/seq_mult_fsm.sv - shift-add sequential multiplier with IDLE/CALC/DONE control FSM
// Define SEQ_MULT_SIGNED_EN for two's-complement operands (sign-magnitude with a final negate).
module seq_mult_fsm #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]           r_state;
  logic [2*WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  logic                 w_accept;
  logic                 w_last_step;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_result;

`ifdef SEQ_MULT_SIGNED_EN
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

  logic r_neg;

  // The most negative value maps to 2^(WIDTH-1), which still fits the unsigned magnitude.
  assign w_a_mag  = a_in[WIDTH-1] ? (~a_in + ONE_W) : a_in;
  assign w_b_mag  = b_in[WIDTH-1] ? (~b_in + ONE_W) : b_in;
  assign w_result = r_neg ? (~w_acc_next + ONE_2W) : w_acc_next;
`else
  assign w_a_mag  = a_in;
  assign w_b_mag  = b_in;
  assign w_result = w_acc_next;
`endif

  assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_acc_next  = r_b[0] ? (r_acc + r_a) : r_acc;
  assign w_last_step = (r_b[WIDTH-1:1] == '0) || (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      r_neg     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state <= S_CALC;
      r_a     <= {{WIDTH{1'b0}}, w_a_mag};
      r_b     <= w_b_mag;
      r_acc   <= '0;
      r_cnt   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      r_neg   <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
`endif
    end else begin
      case (r_state)
        S_CALC: begin
          r_acc <= w_acc_next;
          r_a   <= r_a << 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CNT_ONE;
          // Product is loaded on the same edge that leaves CALC so done and data align.
          if (w_last_step) begin
            r_state   <= S_DONE;
            r_product <= w_result;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == S_CALC);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_seq_mult_fsm.sv
// tb/tb_seq_mult_fsm.sv - randomized and directed bench for seq_mult_fsm against an arithmetic model
module tb_seq_mult_fsm;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks;
  int failures;

  seq_mult_fsm #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b);
    longint pa;
    longint pb;
`ifdef SEQ_MULT_SIGNED_EN
    pa = longint'($signed(a));
    pb = longint'($signed(b));
`else
    pa = longint'(a);
    pb = longint'(b);
`endif
    return 32'(pa * pb);
  endfunction

  function automatic int model_n(input logic [15:0] b);
    int m;
    int n;
`ifdef SEQ_MULT_SIGNED_EN
    m = int'($signed(b));
    if (m < 0) m = -m;
`else
    m = int'(b);
`endif
    n = 1;
    for (int i = 0; i < 17; i++) if (((m >> i) & 1) == 1) n = i + 1;
    return n;
  endfunction

  // Issues one start and returns the observed latency (edges from E0 to done), busy cycles and product.
  task automatic drive_op(input logic [15:0] a, input logic [15:0] b,
                          output int n, output int bc, output logic [31:0] p, output bit to);
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b;
    @(posedge clk);
    #1 start = 1'b0;
    n = -1; bc = 0; p = '0; to = 1'b1;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (done) begin
        n = j; p = product; to = 1'b0;
        break;
      end
      if (busy) bc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (product !== 32'h0) begin failures++; $display("FAIL reset_product got=%h exp=0", product); end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        failures++; $display("FAIL idle_after_reset busy=%0b done=%0b exp=0/0", busy, done);
      end
    end
  endtask

  task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b);
    int n; int bc; logic [31:0] p; bit to;
    logic [31:0] ep; int en;
    ep = model_prod(a, b); en = model_n(b);
    drive_op(a, b, n, bc, p, to);
    checks++; if (to) begin failures++; $display("FAIL %s_timeout no done within 60 cycles", name); end
    checks++; if (p !== ep) begin failures++; $display("FAIL %s_product a=%h b=%h got=%h exp=%h", name, a, b, p, ep); end
    checks++; if (n !== en) begin failures++; $display("FAIL %s_latency b=%h got=%0d exp=%0d", name, b, n, en); end
    checks++; if (bc !== en) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", name, bc, en); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_done_pulse got=%0b exp=0", name, done); end
    checks++; if (product !== ep) begin failures++; $display("FAIL %s_product_hold got=%h exp=%h", name, product, ep); end
  endtask

  task automatic test_directed;
`ifdef SEQ_MULT_SIGNED_EN
    check_op("neg3x5", 16'hFFFD, 16'd5);
    checks++; if (product !== 32'hFFFF_FFF1) begin failures++; $display("FAIL neg3x5_const got=%h exp=fffffff1", product); end
    check_op("minxneg1", 16'h8000, 16'hFFFF);
    checks++; if (product !== 32'h0000_8000) begin failures++; $display("FAIL minxneg1_const got=%h exp=00008000", product); end
    check_op("minxmin", 16'h8000, 16'h8000);
`else
    check_op("ffffxffff", 16'hFFFF, 16'hFFFF);
    checks++; if (product !== 32'hFFFE_0001) begin failures++; $display("FAIL ffffxffff_const got=%h exp=fffe0001", product); end
`endif
    check_op("17x5", 16'd17, 16'd5);
    checks++; if (product !== 32'd85) begin failures++; $display("FAIL 17x5_const got=%h exp=55", product); end
    check_op("msb_b", 16'd3, 16'h4000);
  endtask

  task automatic test_back_to_back;
    int n; int bc; logic [31:0] p; bit to; int k;
    drive_op(16'd1234, 16'd0, n, bc, p, to);
    checks++; if (to || p !== 32'h0) begin failures++; $display("FAIL b2b_first got=%h to=%0b exp=0", p, to); end
    checks++; if (n !== 1) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=1", n); end
    start = 1'b1; a_in = 16'd3; b_in = 16'd4;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_no_idle busy=%0b exp=1", busy); end
    k = -1;
    for (int j = 1; j < 60; j++) begin
      @(negedge clk);
      if (done) begin k = j; break; end
    end
    checks++; if (k !== 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=3", k); end
    checks++; if (product !== 32'd12) begin failures++; $display("FAIL b2b_product got=%h exp=c", product); end
  endtask

  task automatic test_start_ignored;
    int k;
    logic [31:0] ep;
    ep = model_prod(16'd1000, 16'h7001);
    @(negedge clk);
    start = 1'b1; a_in = 16'd1000; b_in = 16'h7001;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; a_in = 16'd7; b_in = 16'd9;
    repeat (2) @(negedge clk);
    start = 1'b0;
    k = -1;
    for (int j = 5; j < 60; j++) begin
      @(negedge clk);
      if (done) begin k = j; break; end
    end
    checks++; if (k !== model_n(16'h7001)) begin failures++; $display("FAIL ignore_latency got=%0d exp=%0d", k, model_n(16'h7001)); end
    checks++; if (product !== ep) begin failures++; $display("FAIL ignore_product got=%h exp=%h", product, ep); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_calc;
    bit seen;
    @(negedge clk);
    start = 1'b1; a_in = 16'd555; b_in = 16'h4321;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_mid_flags busy=%0b done=%0b exp=0/0", busy, done); end
    checks++; if (product !== 32'h0) begin failures++; $display("FAIL rst_mid_product got=%h exp=0", product); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_done activity=%0b exp=0", seen); end
  endtask

  task automatic test_random;
    logic [15:0] a; logic [15:0] b;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if ((i % 3) == 0) b = b >> $urandom_range(15, 0);
      check_op("rand", a, b);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_calc();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
